// File: rtl/branch_predictor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor_if : fetch lookup, resolve/update and statistics bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_i;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_is_jal_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_mispred_i;
    logic            flush_i;
    logic [31:0]     stat_updates_o;
    logic [31:0]     stat_mispred_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_is_jal_i, upd_taken_i,
               upd_target_i, upd_mispred_i, flush_i,
        input  pred_hit_o, pred_taken_o, pred_target_o,
               stat_updates_o, stat_mispred_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_is_jal_i, upd_taken_i,
               upd_target_i, upd_mispred_i, flush_i,
        output pred_hit_o, pred_taken_o, pred_target_o,
               stat_updates_o, stat_mispred_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB with saturating counters and stats
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_MAX >> 1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [31:0]      STAT_MAX    = 32'hFFFF_FFFF;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [31:0]      stat_upd_q, stat_upd_d;
    logic [31:0]      stat_mis_q, stat_mis_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_taken_eff;
    logic             up_write;
    logic [CNT_W-1:0] up_cnt_cur;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0]  target_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};

    // Lookup reads the current table only; a same-cycle update is not bypassed.
    assign lk_idx   = bp.pc_i[IDX_W+1:2];
    assign lk_tag   = bp.pc_i[XLEN-1:IDX_W+2];
    assign lk_hit   = rst & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit & cnt_q[lk_idx][CNT_W-1];

    assign bp.pred_hit_o    = lk_hit;
    assign bp.pred_taken_o  = lk_taken;
    assign bp.pred_target_o = lk_taken ? target_q[lk_idx] : '0;
    assign bp.stat_updates_o = stat_upd_q;
    assign bp.stat_mispred_o = stat_mis_q;

    assign up_idx       = bp.upd_pc_i[IDX_W+1:2];
    assign up_tag       = bp.upd_pc_i[XLEN-1:IDX_W+2];
    assign up_hit       = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
    assign up_taken_eff = bp.upd_is_jal_i | bp.upd_taken_i;
    assign up_write     = up_hit | up_taken_eff;
    assign up_cnt_cur   = cnt_q[up_idx];

    always_comb begin
        cnt_d    = up_cnt_cur;
        target_d = up_taken_eff ? bp.upd_target_i : target_q[up_idx];
        if (bp.upd_is_jal_i) begin
            cnt_d = CNT_MAX;
        end else if (!up_hit) begin
            cnt_d = CNT_WEAK_T;
        end else if (bp.upd_taken_i) begin
            cnt_d = (up_cnt_cur == CNT_MAX) ? up_cnt_cur : up_cnt_cur + CNT_ONE;
        end else begin
            cnt_d = (up_cnt_cur == CNT_ZERO) ? up_cnt_cur : up_cnt_cur - CNT_ONE;
        end
    end

    always_comb begin
        stat_upd_d = (stat_upd_q == STAT_MAX) ? stat_upd_q : stat_upd_q + 32'd1;
        stat_mis_d = stat_mis_q;
        if (bp.upd_mispred_i && stat_mis_q != STAT_MAX) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else if (bp.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WEAK_NT;
            end
        end else if (bp.upd_valid_i) begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
            // A not-taken conditional that misses leaves the table untouched.
            if (up_write) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= target_d;
                cnt_q[up_idx]    <= cnt_d;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predictor : vector table, corner sequences and randomized model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_predictor;
    localparam int     XLEN    = 32;
    localparam int     ENTRIES = 16;
    localparam int     CNT_W   = 2;
    localparam int     CMAX    = (1 << CNT_W) - 1;
    localparam longint SMAX    = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bp_if ();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    longint      m_su, m_sm;

    typedef struct {
        string       name;
        bit          fl;
        bit          v;
        logic [31:0] upc;
        bit          jal;
        bit          tk;
        logic [31:0] tgt;
        bit          mis;
        logic [31:0] lpc;
        bit          eh;
        bit          et;
        logic [31:0] etg;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string n, bit fl, bit v, logic [31:0] upc, bit jal,
                                bit tk, logic [31:0] tgt, bit mis, logic [31:0] lpc,
                                bit eh, bit et, logic [31:0] etg);
        vec_t r;
        r.name = n; r.fl = fl; r.v = v; r.upc = upc; r.jal = jal; r.tk = tk;
        r.tgt = tgt; r.mis = mis; r.lpc = lpc; r.eh = eh; r.et = et; r.etg = etg;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: table semantics expressed with plain integer arithmetic.
    function automatic void model_step();
        longint pc;
        longint tg;
        int     idx;
        bit     hit;
        bit     eff;
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = CMAX / 2;
            end
            m_su = 0;
            m_sm = 0;
        end else if (bp_if.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_cnt[i] = CMAX / 2;
            end
        end else if (bp_if.upd_valid_i) begin
            if (m_su < SMAX) m_su = m_su + 1;
            if (bp_if.upd_mispred_i && m_sm < SMAX) m_sm = m_sm + 1;
            pc  = longint'(bp_if.upd_pc_i);
            idx = int'((pc / 4) % ENTRIES);
            tg  = pc / (4 * ENTRIES);
            eff = bp_if.upd_is_jal_i || bp_if.upd_taken_i;
            hit = m_valid[idx] && (m_tag[idx] == tg);
            if (hit) begin
                if (bp_if.upd_is_jal_i) begin
                    m_cnt[idx] = CMAX;
                    m_tgt[idx] = bp_if.upd_target_i;
                end else if (bp_if.upd_taken_i) begin
                    m_cnt[idx] = (m_cnt[idx] < CMAX) ? m_cnt[idx] + 1 : CMAX;
                    m_tgt[idx] = bp_if.upd_target_i;
                end else begin
                    m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
                end
            end else if (eff) begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
                m_tgt[idx]   = bp_if.upd_target_i;
                m_cnt[idx]   = bp_if.upd_is_jal_i ? CMAX : (CMAX + 1) / 2;
            end
        end
    endfunction

    task automatic check_model(string nm);
        longint      pc;
        int          idx;
        bit          eh;
        bit          et;
        logic [31:0] etg;
        pc  = longint'(bp_if.pc_i);
        idx = int'((pc / 4) % ENTRIES);
        eh  = rst && m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES));
        et  = eh && (m_cnt[idx] >= (CMAX + 1) / 2);
        etg = et ? m_tgt[idx] : 32'h0;
        chk({nm, "_lookup"}, {bp_if.pred_hit_o, bp_if.pred_taken_o, bp_if.pred_target_o},
            {eh, et, etg});
        chk({nm, "_stats"}, {bp_if.stat_updates_o, bp_if.stat_mispred_o},
            {m_su[31:0], m_sm[31:0]});
    endtask

    task automatic chk_look(string nm, bit h, bit t, logic [31:0] g);
        chk(nm, {bp_if.pred_hit_o, bp_if.pred_taken_o, bp_if.pred_target_o}, {h, t, g});
    endtask

    task automatic set_upd(bit v, logic [31:0] pc, bit jal, bit tk, logic [31:0] tgt,
                           bit mis, bit fl);
        bp_if.upd_valid_i   = v;
        bp_if.upd_pc_i      = pc;
        bp_if.upd_is_jal_i  = jal;
        bp_if.upd_taken_i   = tk;
        bp_if.upd_target_i  = tgt;
        bp_if.upd_mispred_i = mis;
        bp_if.flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        vt.push_back(mk("nt1",         0, 1, 'h100, 0, 0, 'h000, 1, 'h100, 1, 0, 'h000));
        vt.push_back(mk("nt2",         0, 1, 'h100, 0, 0, 'h000, 0, 'h100, 1, 0, 'h000));
        vt.push_back(mk("t1",          0, 1, 'h100, 0, 1, 'h080, 0, 'h100, 1, 0, 'h000));
        vt.push_back(mk("t2",          0, 1, 'h100, 0, 1, 'h080, 1, 'h100, 1, 1, 'h080));
        vt.push_back(mk("t3",          0, 1, 'h100, 0, 1, 'h080, 0, 'h100, 1, 1, 'h080));
        vt.push_back(mk("t4_sat",      0, 1, 'h101, 0, 1, 'h084, 0, 'h102, 1, 1, 'h084));
        vt.push_back(mk("nt_hyst",     0, 1, 'h100, 0, 0, 'h000, 0, 'h100, 1, 1, 'h084));
        vt.push_back(mk("nt_hyst2",    0, 1, 'h100, 0, 0, 'h000, 0, 'h100, 1, 0, 'h000));
        vt.push_back(mk("jal",         0, 1, 'h104, 1, 0, 'h200, 1, 'h104, 1, 1, 'h200));
        vt.push_back(mk("alias_alloc", 0, 1, 'h144, 0, 1, 'h300, 0, 'h144, 1, 1, 'h300));
        vt.push_back(mk("alias_evict", 0, 0, 'h000, 0, 0, 'h000, 0, 'h104, 0, 0, 'h000));
        vt.push_back(mk("other_idx",   0, 0, 'h000, 0, 0, 'h000, 0, 'h100, 1, 0, 'h000));
        vt.push_back(mk("jal_hit",     0, 1, 'h100, 1, 0, 'h060, 0, 'h100, 1, 1, 'h060));
        vt.push_back(mk("after_jal",   0, 1, 'h100, 0, 0, 'h000, 0, 'h100, 1, 1, 'h060));
        vt.push_back(mk("miss_nt",     0, 1, 'h208, 0, 0, 'h020, 0, 'h208, 0, 0, 'h000));
        vt.push_back(mk("flush_upd",   1, 1, 'h100, 0, 1, 'h998, 1, 'h100, 0, 0, 'h000));
        vt.push_back(mk("flush_144",   0, 0, 'h000, 0, 0, 'h000, 0, 'h144, 0, 0, 'h000));
        vt.push_back(mk("miss_nt2",    0, 1, 'h100, 0, 0, 'h000, 0, 'h100, 0, 0, 'h000));
        vt.push_back(mk("realloc",     0, 1, 'h100, 0, 1, 'h040, 0, 'h100, 1, 1, 'h040));

        rst = 1'b0;
        bp_if.pc_i = 32'h100;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_look("reset_lookup", 0, 0, 0);
        chk("reset_stats", {bp_if.stat_updates_o, bp_if.stat_mispred_o}, 64'h0);

        set_upd(1, 32'h100, 0, 1, 32'h80, 0, 0);
        #1;
        chk_look("same_cycle", 0, 0, 0);
        tick();
        chk_look("alloc", 1, 1, 32'h80);

        foreach (vt[k]) begin
            set_upd(vt[k].v, vt[k].upc, vt[k].jal, vt[k].tk, vt[k].tgt, vt[k].mis, vt[k].fl);
            bp_if.pc_i = vt[k].lpc;
            tick();
            chk_look(vt[k].name, vt[k].eh, vt[k].et, vt[k].etg);
            check_model(vt[k].name);
        end

        // Reset asserted while an update is presented: update must be lost.
        set_upd(1, 32'h100, 0, 1, 32'h500, 1, 0);
        bp_if.pc_i = 32'h100;
        rst = 1'b0;
        #1;
        chk_look("in_reset_forced", 0, 0, 0);
        tick();
        rst = 1'b1;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_look("post_reset_miss", 0, 0, 0);
        chk("post_reset_stats", {bp_if.stat_updates_o, bp_if.stat_mispred_o}, 64'h0);

        for (int i = 0; i < 5; i++) begin
            set_upd(1, 32'h400 + 32'(i * 4), 0, i[0], 32'h800, (i == 0 || i == 2), 0);
            tick();
        end
        set_upd(0, 0, 0, 0, 0, 0, 0);
        chk("stats_5_2", {bp_if.stat_updates_o, bp_if.stat_mispred_o}, {32'd5, 32'd2});

        @(negedge clk);
        force dut.stat_upd_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_upd_q;
        #1;
        if (bp_if.stat_updates_o == 32'hFFFF_FFFE) begin
            m_su = 64'hFFFF_FFFE;
            for (int i = 0; i < 3; i++) begin
                set_upd(1, 32'h600, 0, 0, 0, 0, 0);
                tick();
            end
            set_upd(0, 0, 0, 0, 0, 0, 0);
            chk("stat_saturate", {32'h0, bp_if.stat_updates_o}, {32'h0, 32'hFFFF_FFFF});
            chk("stat_mis_kept", {32'h0, bp_if.stat_mispred_o}, {32'h0, 32'd2});
        end else begin
            $display("note: counter preload not available, saturation not exercised");
        end

        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) != 0);
            set_upd($urandom_range(0, 2) != 0,
                    32'h1000 + 32'($urandom_range(0, 2) * 64 + $urandom_range(0, 3) * 4
                                   + $urandom_range(0, 3)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 39) == 0);
            bp_if.pc_i = 32'h1000 + 32'($urandom_range(0, 2) * 64 + $urandom_range(0, 3) * 4
                                        + $urandom_range(0, 3));
            #1;
            check_model("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
